// File: rtl/rom_dl_router_pkg.sv
// Shared types and helpers for the ROM download router (package mcr_dl_pkg).
// Region lookup works on zero-extended MAX_ADDR_W addresses so any ADDR_W <= 32 fits.
package mcr_dl_pkg;

    localparam int SEL_W       = 3;
    localparam int MAX_REGIONS = 8;
    localparam int MAX_ADDR_W  = 32;

    typedef enum logic {IDLE, WAIT} dl_state_t;

    // Bases are strictly ascending, so the last base not above addr wins.
    function automatic logic [SEL_W-1:0] region_lookup(
        input logic [MAX_ADDR_W-1:0]                  addr,
        input logic [MAX_REGIONS-1:0][MAX_ADDR_W-1:0] bases,
        input int                                     n
    );
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < MAX_REGIONS; i++) begin
            if (i < n && bases[i] <= addr) sel = i[SEL_W-1:0];
        end
        return sel;
    endfunction

endpackage

// File: rtl/rom_dl_router_if.sv
// ioctl download stream plus per-region req/ack memory port bundle.
// slave = router side, master = hps_io/loader side.
interface rom_dl_router_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 25
);
    logic                   ioctl_download;
    logic                   ioctl_wr;
    logic [ADDR_W-1:0]      ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wait;
    logic [NUM_REGIONS-1:0] port_req;
    logic [NUM_REGIONS-1:0] port_ack;
    logic [ADDR_W-1:0]      port_a;
    logic [7:0]             port_d;
    logic [2:0]             port_sel;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, port_ack,
        output ioctl_wait, port_req, port_a, port_d, port_sel
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, port_ack,
        input  ioctl_wait, port_req, port_a, port_d, port_sel
    );
endinterface

// File: rtl/rom_dl_router_rst_seq.sv
// Core reset sequencer: rom_loaded edge detect, hold counter and registered core_reset
// (including the delayed second pulse when the hold counter passes 1).
module rst_seq #(
    parameter logic [15:0] RST_HOLD = 16'hFFFF
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic user_reset,
    input  logic dl_active,
    output logic rom_loaded,
    output logic core_reset
);

    logic        dl_active_q;
    logic [15:0] hold_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            rom_loaded  <= 1'b0;
            hold_q      <= RST_HOLD;
            core_reset  <= 1'b1;
        end else begin
            dl_active_q <= dl_active;
            if (dl_active_q && !dl_active) rom_loaded <= 1'b1;
            if (user_reset || !rom_loaded)
                hold_q <= RST_HOLD;
            else if (hold_q != 16'd0)
                hold_q <= hold_q - 16'd1;
            core_reset <= user_reset | dl_active | ~rom_loaded | (hold_q == 16'd1);
        end
    end

endmodule

// File: rtl/rom_dl_router.sv
// ROM download router: maps ioctl writes onto per-region toggle req/ack ports.
// Optional ack watchdog is built when DL_TIMEOUT_EN is defined.
module rom_dl_router
    import mcr_dl_pkg::*;
#(
    parameter int                          NUM_REGIONS = 4,
    parameter int                          ADDR_W      = 25,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {25'h32000, 25'h12000, 25'h0E000, 25'h00000},
    parameter logic [ADDR_W-1:0]           ROM_END     = 25'h3A000,
    parameter logic [7:0]                  ROM_INDEX   = 8'd0,
    parameter logic [15:0]                 RST_HOLD    = 16'hFFFF,
    parameter int                          ACK_TIMEOUT = 1023
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   user_reset,
    rom_dl_router_if.slave         bus,
    output logic                   rom_loaded,
    output logic                   core_reset,
    output logic                   dl_err
);

    function automatic logic [NUM_REGIONS-1:0] sel_oh(input logic [SEL_W-1:0] s);
        logic [NUM_REGIONS-1:0] oh;
        for (int i = 0; i < NUM_REGIONS; i++) oh[i] = (s == i[SEL_W-1:0]);
        return oh;
    endfunction

    dl_state_t              state_q, state_nxt;
    logic [NUM_REGIONS-1:0] req_q, req_nxt, oh_cur;
    logic [ADDR_W-1:0]      a_q, a_nxt;
    logic [7:0]             d_q, d_nxt;
    logic [SEL_W-1:0]       sel_q, sel_nxt, sel_new;
    logic                   wait_q, wait_nxt, err_q, err_nxt;
    logic                   dl_active, wr_ok, busy_wr, acked, timeout;
    logic [MAX_REGIONS-1:0][MAX_ADDR_W-1:0] bases_ext;
    logic [MAX_ADDR_W-1:0]  addr_ext;

    always_comb begin
        bases_ext = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            bases_ext[i][ADDR_W-1:0] = REGION_BASE[i*ADDR_W +: ADDR_W];
        addr_ext = '0;
        addr_ext[ADDR_W-1:0] = bus.ioctl_addr;
    end

    assign dl_active = bus.ioctl_download && (bus.ioctl_index == ROM_INDEX);
    assign wr_ok     = bus.ioctl_wr && dl_active && (bus.ioctl_addr < ROM_END);
    assign busy_wr   = bus.ioctl_wr && dl_active;
    assign sel_new   = region_lookup(addr_ext, bases_ext, NUM_REGIONS);
    assign oh_cur    = sel_oh(sel_q);
    assign acked     = (|(bus.port_ack & oh_cur)) == (|(req_q & oh_cur));

`ifdef DL_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge clk_sys) begin
        if (reset || state_q != WAIT) tmo_q <= '0;
        else                          tmo_q <= tmo_q + TMO_W'(1);
    end

    assign timeout = (state_q == WAIT) && !acked && (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            sel_q   <= '0;
            wait_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            req_q   <= req_nxt;
            a_q     <= a_nxt;
            d_q     <= d_nxt;
            sel_q   <= sel_nxt;
            wait_q  <= wait_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (wr_ok) state_nxt = WAIT;
            WAIT:    if (acked || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A write landing in WAIT only flags the error; it never disturbs the pending transfer.
    always_comb begin
        req_nxt  = req_q;
        a_nxt    = a_q;
        d_nxt    = d_q;
        sel_nxt  = sel_q;
        wait_nxt = wait_q;
        err_nxt  = err_q;
        case (state_q)
            IDLE: begin
                if (wr_ok) begin
                    a_nxt    = bus.ioctl_addr - bases_ext[sel_new][ADDR_W-1:0];
                    d_nxt    = bus.ioctl_dout;
                    sel_nxt  = sel_new;
                    req_nxt  = req_q ^ sel_oh(sel_new);
                    wait_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (busy_wr) err_nxt = 1'b1;
                if (acked) begin
                    wait_nxt = 1'b0;
                end else if (timeout) begin
                    req_nxt  = (req_q & ~oh_cur) | (bus.port_ack & oh_cur);
                    wait_nxt = 1'b0;
                    err_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.port_req   = req_q;
    assign bus.port_a     = a_q;
    assign bus.port_d     = d_q;
    assign bus.port_sel   = sel_q;
    assign dl_err         = err_q;

    rst_seq #(.RST_HOLD(RST_HOLD)) u_rst_seq (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .user_reset (user_reset),
        .dl_active  (dl_active),
        .rom_loaded (rom_loaded),
        .core_reset (core_reset)
    );

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: table of region-mapping writes plus hand sequences
// for busy writes, reset sequencing, mid-transfer reset and (with DL_TIMEOUT_EN) the watchdog.
module tb_rom_dl_router;
    import mcr_dl_pkg::*;

    localparam int          HOLD = 20;
    localparam int          TMO  = 16;

    logic clk_sys = 1'b0;
    logic reset, user_reset;
    logic rom_loaded, core_reset, dl_err;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] exp_req;

    rom_dl_router_if #(.NUM_REGIONS(4), .ADDR_W(25)) bus ();

    rom_dl_router #(
        .NUM_REGIONS (4),
        .ADDR_W      (25),
        .RST_HOLD    (16'(HOLD)),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .user_reset (user_reset),
        .bus        (bus),
        .rom_loaded (rom_loaded),
        .core_reset (core_reset),
        .dl_err     (dl_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        drop;
        logic [2:0]  sel;
        logic [24:0] a;
        int          ack_dly;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic apply_write(input vec_t v);
        int bad;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = v.addr;
        bus.ioctl_dout = v.data;
        step();
        bus.ioctl_wr = 1'b0;
        if (v.drop) begin
            chk("drop_req", 32'(bus.port_req), 32'(exp_req));
            chk("drop_wait", 32'(bus.ioctl_wait), 0);
            chk("drop_err", 32'(dl_err), 0);
            step();
            chk("drop_wait2", 32'(bus.ioctl_wait), 0);
        end else begin
            exp_req[v.sel] = ~exp_req[v.sel];
            chk("req", 32'(bus.port_req), 32'(exp_req));
            chk("sel", 32'(bus.port_sel), 32'(v.sel));
            chk("port_a", 32'(bus.port_a), 32'(v.a));
            chk("port_d", 32'(bus.port_d), 32'(v.data));
            bad = 0;
            for (int k = 0; k < v.ack_dly; k++) begin
                if (bus.ioctl_wait !== 1'b1) bad++;
                step();
            end
            chk("wait_held", 32'(bad), 0);
            bus.port_ack = exp_req;
            step();
            chk("wait_drop", 32'(bus.ioctl_wait), 0);
            chk("req_after", 32'(bus.port_req), 32'(exp_req));
        end
    endtask

    // Measures cycles from core_reset low to the delayed pulse, then checks it is one cycle wide.
    task automatic measure_pulse(input string name);
        int n;
        int hi;
        n = 0;
        while (core_reset !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({name, "_delay"}, 32'(n), 32'(HOLD - 1));
        step();
        chk({name, "_width"}, 32'(core_reset), 0);
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            if (core_reset !== 1'b0) hi++;
            step();
        end
        chk({name, "_stays_low"}, 32'(hi), 0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{25'h0E004, 8'hA5, 1'b0, 3'd1, 25'h00004, 5};
        vecs[1] = '{25'h12000, 8'h3C, 1'b0, 3'd2, 25'h00000, 1};
        vecs[2] = '{25'h31FFF, 8'h77, 1'b0, 3'd2, 25'h1FFFF, 2};
        vecs[3] = '{25'h32000, 8'h81, 1'b0, 3'd3, 25'h00000, 3};
        vecs[4] = '{25'h3A000, 8'hEE, 1'b1, 3'd0, 25'h00000, 0};
        vecs[5] = '{25'h00010, 8'h5A, 1'b0, 3'd0, 25'h00010, 1};
        vecs[6] = '{25'h39FFF, 8'hFF, 1'b0, 3'd3, 25'h07FFF, 4};
        vecs[7] = '{25'h0DFFF, 8'h11, 1'b0, 3'd0, 25'h0DFFF, 2};

        reset = 1'b1;
        user_reset = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_dout = '0;
        bus.ioctl_index = 8'd0;
        bus.port_ack = '0;
        exp_req = '0;
        step();
        step();
        reset = 1'b0;

        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (core_reset !== 1'b1 || rom_loaded !== 1'b0 || bus.port_req !== 4'd0 ||
                bus.ioctl_wait !== 1'b0 || dl_err !== 1'b0) bad++;
            step();
        end
        chk("reset_idle", 32'(bad), 0);
        chk("reset_port_a", 32'(bus.port_a), 0);
        chk("reset_sel", 32'(bus.port_sel), 0);

        // Non-ROM index: write must vanish entirely.
        bus.ioctl_download = 1'b1;
        bus.ioctl_index = 8'd1;
        step();
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 25'h00100;
        bus.ioctl_dout = 8'h12;
        step();
        bus.ioctl_wr = 1'b0;
        chk("idx_req", 32'(bus.port_req), 0);
        chk("idx_wait", 32'(bus.ioctl_wait), 0);
        chk("idx_port_d", 32'(bus.port_d), 0);

        bus.ioctl_index = 8'd0;
        step();
        chk("dl_core_reset", 32'(core_reset), 1);

        for (int i = 0; i < 8; i++) apply_write(vecs[i]);
        chk("err_clean", 32'(dl_err), 0);

        // Second write while waiting for ack: flagged and dropped.
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 25'h0E010;
        bus.ioctl_dout = 8'h42;
        step();
        exp_req[1] = ~exp_req[1];
        bus.ioctl_addr = 25'h0E020;
        bus.ioctl_dout = 8'h99;
        step();
        bus.ioctl_wr = 1'b0;
        chk("busy_err", 32'(dl_err), 1);
        chk("busy_req", 32'(bus.port_req), 32'(exp_req));
        chk("busy_a", 32'(bus.port_a), 32'h10);
        chk("busy_d", 32'(bus.port_d), 32'h42);
        chk("busy_wait", 32'(bus.ioctl_wait), 1);
        bus.port_ack = exp_req;
        step();
        chk("busy_done", 32'(bus.ioctl_wait), 0);
        chk("busy_req2", 32'(bus.port_req), 32'(exp_req));

`ifdef DL_TIMEOUT_EN
        begin
            int n;
            bus.ioctl_wr = 1'b1;
            bus.ioctl_addr = 25'h32004;
            bus.ioctl_dout = 8'h66;
            step();
            bus.ioctl_wr = 1'b0;
            n = 0;
            while (bus.ioctl_wait === 1'b1 && n < 100) begin
                step();
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'(TMO));
            chk("tmo_err", 32'(dl_err), 1);
            chk("tmo_req_eq_ack", 32'(bus.port_req), 32'(exp_req));
            chk("tmo_wait", 32'(bus.ioctl_wait), 0);
        end
`endif

        // Download ends: rom_loaded, core_reset release, delayed pulse.
        bus.ioctl_download = 1'b0;
        step();
        chk("loaded", 32'(rom_loaded), 1);
        chk("core_reset_lag", 32'(core_reset), 1);
        step();
        chk("core_reset_rel", 32'(core_reset), 0);
        measure_pulse("pulse");
        chk("loaded_sticky", 32'(rom_loaded), 1);

        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        chk("ureset_core", 32'(core_reset), 1);
        step();
        chk("ureset_rel", 32'(core_reset), 0);
        measure_pulse("upulse");

        // Reset during a transfer: req cancelled, peer clears its ack too.
        bus.ioctl_download = 1'b1;
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 25'h12345;
        bus.ioctl_dout = 8'hC3;
        step();
        bus.ioctl_wr = 1'b0;
        chk("mid_wait", 32'(bus.ioctl_wait), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.port_ack = '0;
        exp_req = '0;
        chk("mid_req", 32'(bus.port_req), 0);
        chk("mid_wait_clr", 32'(bus.ioctl_wait), 0);
        chk("mid_loaded", 32'(rom_loaded), 0);
        chk("mid_err", 32'(dl_err), 0);
        chk("mid_core_reset", 32'(core_reset), 1);

        apply_write(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Routes the HPS ioctl ROM download stream into up to NUM_REGIONS memory ports. Each region is an SDRAM port or a BRAM loader.
- Per port: region-relative address, toggle req/ack handshake, backpressure on ioctl_wait.
- Also owns rom_loaded tracking and core reset sequencing, including the delayed second reset pulse.
- Sits between hps_io and the sdram/BRAM loaders in every MCR-family top level.

Parameters:
- NUM_REGIONS, 4, number of download targets (1..8).
- ADDR_W, 25, ioctl address width.
- REGION_BASE, {25'h32000,25'h12000,25'h0E000,25'h00000}, packed NUM_REGIONS*ADDR_W start offsets. Slot i is bits [i*ADDR_W +: ADDR_W]. Slots are strictly ascending with i.
- ROM_END, 25'h3A000, first address past the image; writes at or above it are dropped.
- ROM_INDEX, 0, ioctl_index value that selects ROM download.
- RST_HOLD, 16'hFFFF, delay from reset release to the second reset pulse.
- ACK_TIMEOUT, 1023, watchdog limit in cycles (used only with DL_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- user_reset  in  1  OSD/button reset request
- ioctl_download  in  1  download active
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_addr  in  ADDR_W  byte address
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  download index
- ioctl_wait  out  1  backpressure to hps_io
- port_req  out  NUM_REGIONS  per-region toggle request
- port_ack  in  NUM_REGIONS  per-region toggle acknowledge
- port_a  out  ADDR_W  region-relative byte address
- port_d  out  8  write byte
- port_sel  out  3  index of the active region
- rom_loaded  out  1  sticky: ROM image complete
- core_reset  out  1  reset to game core
- dl_err  out  1  sticky: write while busy, or timeout

Behaviour:
- Reset values: port_req=0, port_a=0, port_d=0, port_sel=0, ioctl_wait=0, rom_loaded=0, dl_err=0, core_reset=1, FSM=IDLE, hold counter=RST_HOLD.
- The peer must also clear port_ack on reset, so the req/ack toggles start equal.
- dl_active = ioctl_download && ioctl_index==ROM_INDEX.
- FSM IDLE:
  - Trigger: ioctl_wr && dl_active && ioctl_addr<ROM_END.
  - Select i = highest region with REGION_BASE[i] <= ioctl_addr.
  - Register port_a = ioctl_addr - REGION_BASE[i], truncated to ADDR_W. Register port_d = ioctl_dout and port_sel = i.
  - Toggle port_req[i]; move to WAIT.
  - ioctl_wait is high from the following cycle.
- FSM WAIT:
  - Exit when port_ack[port_sel]==port_req[port_sel]; return to IDLE and drop ioctl_wait in that same cycle (registered). Minimum write-to-write spacing is 3 cycles.
  - ioctl_wr arriving in WAIT: the byte is dropped, dl_err is set, the FSM is unaffected.
- Dropped writes:
  - Addresses at or above ROM_END: ignored, no req, no error.
  - Writes with a non-ROM ioctl_index: ignored entirely.
- Simultaneous ack-match and ioctl_wr in WAIT: counted as write-while-busy. The hps_io contract forbids this case.
- rom_loaded is set on the falling edge of dl_active, detected by a registered previous value. It never clears except on reset.
- Hold counter:
  - Forced to RST_HOLD while reset|user_reset|~rom_loaded.
  - Otherwise decrements to 0 and stops.
- core_reset = reset | user_reset | dl_active | ~rom_loaded | (hold==1). This is registered, one cycle of latency.
- Reset mid-transfer: the FSM aborts to IDLE immediately and the in-flight byte is lost. Loaders must ignore a req toggle that is cancelled by reset.

Optional Feature:
- Macro DL_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If it reaches ACK_TIMEOUT without an ack: force port_req[port_sel] back to equal port_ack[port_sel], set dl_err, return to IDLE, release ioctl_wait.
- When undefined: WAIT persists indefinitely and no counter logic is generated.

Decomposition:
- Package mcr_dl_pkg holds:
  - typedef enum {IDLE, WAIT} dl_state_t;
  - localparam SEL_W=3 and MAX_REGIONS=8;
  - function region_lookup(addr, bases, n) returning the region index.
- Sub-module rst_seq contains the hold counter, the rom_loaded edge detector and the core_reset register. The FSM and address mapping stay in the top module.

Test Plan:
- Reset then idle: core_reset=1, rom_loaded=0, port_req=0 across 10 cycles.
- ioctl_wr at addr 0x0E004 with data 0xA5, ack returned 5 cycles later:
  - port_sel=1, port_a=0x4, port_d=0xA5, port_req[1] toggles once.
  - ioctl_wait high for exactly the cycles until ack, then low.
- Write at 0x12000 / 0x31FFF / 0x32000 / 0x3A000: region 2 offset 0 / region 2 offset 0x1FFFF / region 3 offset 0 / dropped with no req and dl_err=0.
- Second ioctl_wr while in WAIT: dl_err=1, only one req toggle, the first byte completes.
- Download falls from 1 to 0:
  - rom_loaded=1 next cycle, core_reset deasserts.
  - core_reset pulses for exactly one cycle RST_HOLD-1 cycles later, then stays 0; user_reset restarts the sequence.
- With DL_TIMEOUT_EN defined and ACK_TIMEOUT=16, ack withheld: FSM returns to IDLE after 16 cycles, dl_err=1, port_req equals port_ack, ioctl_wait=0.
